// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register busy/countdown/speculation scoreboard that
// resolves RAW by forwarding or stalling, blocks WAW, and squashes on flush.
module hazard_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = 5,
   parameter int LAT_W    = 3,
   parameter int FWD_EN   = 1,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                id_valid,
   input  logic [REG_W-1:0]    id_rs1,
   input  logic [REG_W-1:0]    id_rs2,
   input  logic                id_rs1_en,
   input  logic                id_rs2_en,
   input  logic [REG_W-1:0]    id_rd,
   input  logic                id_rd_we,
   input  logic [LAT_W-1:0]    id_lat,
   input  logic                id_spec,
   input  logic                wb_valid,
   input  logic [REG_W-1:0]    wb_rd,
   input  logic                branch_resolve,
   input  logic                flush,
   input  logic                stall_in,
   output logic                stall,
   output logic                fwd_rs1,
   output logic                fwd_rs2,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    stall_cycles
);

   localparam logic FWD = (FWD_EN != 0);

   logic [NUM_REGS-1:0]            busy_q, busy_d;
   logic [NUM_REGS-1:0]            spec_q, spec_d;
   logic [NUM_REGS-1:0][LAT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0]               stall_cycles_q, stall_cycles_d;

   logic rs1_haz, rs2_haz, rs1_stall, rs2_stall, waw_haz, haz_stall, issue;

   // A same-cycle writeback removes a hazard because the register file is write-first.
   always_comb begin
      rs1_haz   = id_rs1_en && (id_rs1 != '0) && busy_q[id_rs1] &&
                  !(wb_valid && (wb_rd == id_rs1));
      rs2_haz   = id_rs2_en && (id_rs2 != '0) && busy_q[id_rs2] &&
                  !(wb_valid && (wb_rd == id_rs2));
      rs1_stall = rs1_haz && (!FWD || (cnt_q[id_rs1] != '0));
      rs2_stall = rs2_haz && (!FWD || (cnt_q[id_rs2] != '0));
      fwd_rs1   = FWD && rs1_haz && (cnt_q[id_rs1] == '0);
      fwd_rs2   = FWD && rs2_haz && (cnt_q[id_rs2] == '0);
      waw_haz   = id_rd_we && (id_rd != '0) && busy_q[id_rd] &&
                  !(wb_valid && (wb_rd == id_rd));
      haz_stall = id_valid && (rs1_stall || rs2_stall || waw_haz);
      stall     = haz_stall || stall_in;
      issue     = id_valid && id_rd_we && (id_rd != '0) && !stall && !flush;
   end

   always_comb begin
      busy_d = busy_q;
      spec_d = spec_q;
      cnt_d  = cnt_q;
      for (int r = 0; r < NUM_REGS; r++) begin
         if (r == 0) begin
            busy_d[r] = 1'b0;
            spec_d[r] = 1'b0;
            cnt_d[r]  = '0;
         end else if (issue && (id_rd == REG_W'(r))) begin
            busy_d[r] = 1'b1;
            spec_d[r] = id_spec;
            cnt_d[r]  = id_lat;
         end else if (flush && spec_q[r]) begin
            busy_d[r] = 1'b0;
            spec_d[r] = 1'b0;
            cnt_d[r]  = '0;
         end else if (wb_valid && (wb_rd == REG_W'(r))) begin
            busy_d[r] = 1'b0;
            spec_d[r] = 1'b0;
            cnt_d[r]  = '0;
         end else begin
            if (branch_resolve) spec_d[r] = 1'b0;
            if (busy_q[r] && (cnt_q[r] != '0)) cnt_d[r] = cnt_q[r] - LAT_W'(1);
         end
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (haz_stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q         <= '0;
         spec_q         <= '0;
         cnt_q          <= '0;
         stall_cycles_q <= '0;
      end else begin
         busy_q         <= busy_d;
         spec_q         <= spec_d;
         cnt_q          <= cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign busy_vec     = busy_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding, no-forwarding and narrow-counter
// instances share one stimulus stream; expectations queue up and are popped on sampling.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_rs1_en, id_rs2_en, id_rd_we, id_spec;
   logic [4:0] id_rs1, id_rs2, id_rd, wb_rd;
   logic [2:0] id_lat;
   logic       wb_valid, branch_resolve, flush, stall_in;

   logic        stall_f, fwd1_f, fwd2_f;
   logic [31:0] busy_f, sc_f;
   logic        stall_n, fwd1_n, fwd2_n;
   logic [31:0] busy_n, sc_n;
   logic        stall_s, fwd1_s, fwd2_s;
   logic [31:0] busy_s;
   logic [3:0]  sc_s;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;
   exp_t exp_q[$];

   always #5 clk = ~clk;

   hazard_scoreboard u_fwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .id_lat(id_lat), .id_spec(id_spec), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .branch_resolve(branch_resolve), .flush(flush), .stall_in(stall_in),
      .stall(stall_f), .fwd_rs1(fwd1_f), .fwd_rs2(fwd2_f), .busy_vec(busy_f),
      .stall_cycles(sc_f));

   hazard_scoreboard #(.FWD_EN(0)) u_nofwd (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .id_lat(id_lat), .id_spec(id_spec), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .branch_resolve(branch_resolve), .flush(flush), .stall_in(stall_in),
      .stall(stall_n), .fwd_rs1(fwd1_n), .fwd_rs2(fwd2_n), .busy_vec(busy_n),
      .stall_cycles(sc_n));

   hazard_scoreboard #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_en(id_rs1_en), .id_rs2_en(id_rs2_en), .id_rd(id_rd), .id_rd_we(id_rd_we),
      .id_lat(id_lat), .id_spec(id_spec), .wb_valid(wb_valid), .wb_rd(wb_rd),
      .branch_resolve(branch_resolve), .flush(flush), .stall_in(stall_in),
      .stall(stall_s), .fwd_rs1(fwd1_s), .fwd_rs2(fwd2_s), .busy_vec(busy_s),
      .stall_cycles(sc_s));

   task automatic expect_val(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed %0h expected none queued", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_valid = 0; id_rs1_en = 0; id_rs2_en = 0; id_rd_we = 0; id_spec = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_lat = 0;
      wb_valid = 0; wb_rd = 0; branch_resolve = 0; flush = 0; stall_in = 0;
   endtask

   task automatic do_reset();
      idle();
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [2:0] lat, input logic spec);
      idle();
      id_valid = 1; id_rd_we = 1; id_rd = rd; id_lat = lat; id_spec = spec;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      idle();
      rst = 1;
      #3;
      // Reset state
      expect_val("rst_busy", 0);        check(busy_f);
      expect_val("rst_sc", 0);          check(sc_f);
      expect_val("rst_stall", 0);       check({31'b0, stall_f});
      stall_in = 1;
      #1;
      expect_val("rst_stall_in", 1);    check({31'b0, stall_f});
      expect_val("rst_fwd1", 0);        check({31'b0, fwd1_f});
      @(posedge clk);
      #1 rst = 0;

      // Dependent forward: x5 lat=2
      issue(5, 2, 0);
      #1;
      expect_val("fw_issue_stall", 0);  check({31'b0, stall_f});
      tick();
      idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 5;
      #1;
      expect_val("fw_c1_stall", 1);     check({31'b0, stall_f});
      expect_val("fw_c1_fwd", 0);       check({31'b0, fwd1_f});
      tick();
      expect_val("fw_c2_stall", 1);     check({31'b0, stall_f});
      tick();
      expect_val("fw_c3_stall", 0);     check({31'b0, stall_f});
      expect_val("fw_c3_fwd", 1);       check({31'b0, fwd1_f});
      expect_val("fw_c3_busy5", 1);     check({31'b0, busy_f[5]});
      tick();
      expect_val("fw_stall_cycles", 2); check(sc_f);

      // No-forward mode: x7 lat=0
      do_reset();
      issue(7, 0, 0);
      tick();
      idle(); id_valid = 1; id_rs2_en = 1; id_rs2 = 7;
      #1;
      expect_val("nf_c1_stall", 1);     check({31'b0, stall_n});
      expect_val("nf_c1_fwd", 0);       check({31'b0, fwd2_n});
      expect_val("lat0_fwd", 1);        check({31'b0, fwd2_f});
      expect_val("lat0_stall", 0);      check({31'b0, stall_f});
      tick();
      expect_val("nf_c2_stall", 1);     check({31'b0, stall_n});
      wb_valid = 1; wb_rd = 7;
      #1;
      expect_val("nf_wb_stall", 0);     check({31'b0, stall_n});
      expect_val("nf_wb_fwd", 0);       check({31'b0, fwd2_n});
      expect_val("wb_fwd_drop", 0);     check({31'b0, fwd2_f});
      tick();
      expect_val("nf_busy7", 0);        check({31'b0, busy_n[7]});

      // WAW and writeback in the same cycle as a new issue
      do_reset();
      issue(3, 3, 0);
      tick();
      issue(3, 1, 0);
      #1;
      expect_val("waw_stall", 1);       check({31'b0, stall_f});
      tick();
      wb_valid = 1; wb_rd = 3;
      #1;
      expect_val("waw_wb_stall", 0);    check({31'b0, stall_f});
      tick();
      expect_val("waw_busy3", 1);       check({31'b0, busy_f[3]});
      idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 3;
      #1;
      expect_val("waw_new_cnt_stall", 1); check({31'b0, stall_f});

      // Speculation: flush squashes x4 only; x8 in ID during flush is dropped
      do_reset();
      issue(4, 3, 1);
      tick();
      issue(6, 3, 0);
      tick();
      issue(8, 3, 0);
      flush = 1;
      #1;
      expect_val("flush_stall", 0);     check({31'b0, stall_f});
      tick();
      expect_val("flush_busy", 32'h40); check(busy_f);

      do_reset();
      issue(4, 3, 1);
      tick();
      issue(6, 3, 0);
      tick();
      idle(); branch_resolve = 1;
      tick();
      idle(); flush = 1;
      tick();
      expect_val("resolve_busy", 32'h50); check(busy_f);

      do_reset();
      issue(4, 3, 1);
      branch_resolve = 1;
      tick();
      idle(); flush = 1;
      tick();
      expect_val("resolve_issue_spec", 0); check(busy_f);

      // x0 destination and disabled source
      do_reset();
      issue(0, 3, 0);
      tick();
      expect_val("x0_busy", 0);         check(busy_f);
      issue(9, 3, 0);
      tick();
      idle(); id_valid = 1; id_rs1 = 9;
      #1;
      expect_val("rs1_dis_stall", 0);   check({31'b0, stall_f});
      id_rs1_en = 1;
      #1;
      expect_val("rs1_en_stall", 1);    check({31'b0, stall_f});

      // Asynchronous reset mid-countdown
      do_reset();
      issue(5, 7, 0);
      tick();
      idle(); id_valid = 1; id_rs1_en = 1; id_rs1 = 5;
      #1;
      expect_val("pre_rst_stall", 1);   check({31'b0, stall_f});
      #1 rst = 1;
      #1;
      expect_val("async_rst_stall", 0); check({31'b0, stall_f});
      expect_val("async_rst_busy", 0);  check(busy_f);
      @(posedge clk);
      #1 rst = 0;

      // stall_in alone is not counted
      idle(); id_valid = 1; stall_in = 1;
      tick(); tick(); tick();
      expect_val("stall_in_out", 1);    check({31'b0, stall_f});
      expect_val("stall_in_sc", 0);     check(sc_f);

      // Saturation: 20 WAW hazard cycles
      do_reset();
      issue(2, 7, 0);
      tick();
      issue(2, 1, 0);
      for (int i = 0; i < 20; i++) tick();
      expect_val("sat_sc4", 15);        check({28'b0, sc_s});
      expect_val("sat_sc32", 20);       check(sc_f);
      expect_val("sat_sc32_nf", 20);    check(sc_n);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised scoreboard-based hazard unit for the RISC-V pipeline. It tracks every in-flight register write with a busy bit, a latency countdown and a speculation flag. It resolves RAW hazards by either forwarding or stalling, blocks WAW issue, and squashes speculative entries on a branch flush. It sits at the ID stage, between decode and the issue register. It also keeps a saturating stall-cycle performance counter.

## Interface

Parameters:
- NUM_REGS, 32: architectural registers tracked. Register 0 is never tracked.
- REG_W, 5: register index width; equals clog2(NUM_REGS).
- LAT_W, 3: latency countdown width; maximum latency is 2^LAT_W-1.
- FWD_EN, 1: 1 = forwarding exists (stall only while cnt≠0); 0 = stall until writeback.
- CNT_W, 32: stall-cycle counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  instruction present in ID.
- id_rs1, id_rs2  in  REG_W  source indices.
- id_rs1_en, id_rs2_en  in  1  source actually read.
- id_rd  in  REG_W  destination index.
- id_rd_we  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles after issue until the result is forwardable.
- id_spec  in  1  instruction issued under an unresolved branch.
- wb_valid  in  1  register-file write this cycle.
- wb_rd  in  REG_W  register-file write index.
- branch_resolve  in  1  the oldest unresolved branch resolved not-taken.
- flush  in  1  the oldest unresolved branch mispredicted; squash speculative entries.
- stall_in  in  1  external stall (memory, accelerator).
- stall  out  1  hold ID/IF this cycle.
- fwd_rs1, fwd_rs2  out  1  the source must take its operand from the bypass network.
- busy_vec  out  NUM_REGS  registered busy bits. Bit 0 is always 0.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

## Operation

- Each register r≥1 has three fields: busy[r], cnt[r] (LAT_W bits) and spec[r]. All are cleared by rst.
- Source hazard, for s in {rs1, rs2}:
  - Condition: s_en, s≠0, busy[s], and not (wb_valid and wb_rd==s). The register file is write-first, so a same-cycle writeback removes the hazard.
  - Stall condition: the source hazard holds and (FWD_EN==0 or cnt[s]≠0).
  - Forward condition: fwd_s = FWD_EN and the source hazard holds and cnt[s]==0.
- WAW hazard: id_rd_we, id_rd≠0, busy[id_rd], and not (wb_valid and wb_rd==id_rd).
- stall = id_valid and (source stall on rs1 or rs2, or WAW), or stall_in. The output is combinational and has no dependency on flush.
- Issue fires when id_valid, id_rd_we, id_rd≠0, !stall and !flush. On issue: busy[id_rd]←1, cnt[id_rd]←id_lat, spec[id_rd]←id_spec.
- Every cycle, each busy entry with cnt≠0 that is not being issued decrements by 1 and saturates at 0.
- Writeback: wb_valid with wb_rd≠0 clears busy, cnt and spec of that entry.
- branch_resolve clears all spec bits. It only demotes entries; it never clears busy.
- flush clears busy, cnt and spec for every entry with spec=1. Non-speculative entries are untouched.
- Same-cycle priority per entry, highest first:
  1. Issue. A new producer overrides a writeback to the same rd; only a same-cycle writeback releases the WAW hazard, so this case can occur.
  2. flush.
  3. Writeback.
  4. branch_resolve, then decrement.
- An issue in the same cycle as branch_resolve keeps the id_spec value given with it.
- stall_cycles increments when id_valid and the hazard part of stall (excluding stall_in) is 1. It saturates at all-ones.

## Timing

- Reset values: busy_vec=0, stall_cycles=0. stall=stall_in. fwd_rs1=fwd_rs2=0.
- Scoreboard updates on the rising clk edge. rst acts immediately, independent of clk.
- Issue at edge T with id_lat=L:
  - busy_vec shows the entry after T.
  - A dependant in ID sees cnt=L during cycle T+1 and stalls while cnt≠0.
  - With FWD_EN=1 it forwards in cycle T+1+L with no stall.
  - With FWD_EN=0 it stalls until the cycle in which the matching writeback is presented.
- id_lat=0: a dependant in the next cycle forwards immediately.
- flush takes effect at the next edge. An instruction in ID during flush is not recorded.
- rst asserted mid-stall drops stall (except stall_in) within the same cycle.

## Test plan

- Dependent forward (FWD_EN=1): issue x5 with lat=2 at cycle 0; rs1=x5 in cycles 1..3 → stall=1 in cycles 1–2; stall=0 and fwd_rs1=1 in cycle 3; stall_cycles=2.
- No-forward mode (FWD_EN=0): issue x7 with lat=0, then rs2=x7 → stall holds until the cycle with wb_valid and wb_rd=7, then releases the same cycle with fwd_rs2=0; busy_vec[7]=0 afterwards.
- WAW and simultaneous events:
  - x3 busy; a new write to x3 → stall=1.
  - Same cycle as wb_rd=3 → stall=0 and the issue re-sets busy[3]=1; busy_vec[3] stays 1 after the edge.
- Speculation:
  - Issue x4 with spec=1 and x6 with spec=0; flush → busy_vec[4]=0, busy_vec[6]=1.
  - Repeat with branch_resolve before flush → both remain busy.
- x0 and disabled sources:
  - id_rd=0 with we=1 → busy_vec unchanged.
  - rs1=x9 busy with id_rs1_en=0 → stall=0.
- Reset and saturation:
  - Assert rst mid-countdown → busy_vec=0, stall=0 asynchronously.
  - With CNT_W=4, hold a hazard for 20 cycles → stall_cycles=15.
